// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: FSM encoding, default
// widths and the flattened result-element offset used by the array and the reader.
package matmul_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUS_WIDTH_DEF  = 16;
    localparam int MAX_DIM_DEF    = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    function automatic int unsigned elem_off(int unsigned r, int unsigned c,
                                             int unsigned dim, int unsigned bw);
        return (r * dim + c) * bw;
    endfunction

endpackage

// File: rtl/result_matrix_reader_if.sv
// Bus-side ports of the result reader: random-access read port plus drain stream.
// Stream handshake: an element transfers on a clock edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, out_data and out_last hold steady.
interface result_matrix_reader_if #(
    parameter int BUS_WIDTH = 16,
    parameter int IDX_W     = 1
);
    logic                 rd_en;
    logic [IDX_W-1:0]     rd_row;
    logic [IDX_W-1:0]     rd_col;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 stream_start;
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output rd_en, rd_row, rd_col, stream_start, out_ready,
        input  rd_data, rd_valid, out_data, out_valid, out_last
    );

    modport slave (
        input  rd_en, rd_row, rd_col, stream_start, out_ready,
        output rd_data, rd_valid, out_data, out_valid, out_last
    );
endinterface

// File: rtl/result_matrix_reader_stream_ctrl.sv
// IDLE/HOLD/STREAM sequencing for the result reader: row/col drain counters,
// valid/last generation, capture qualification and the sticky overrun flag.
module rm_stream_ctrl
    import matmul_pkg::*;
#(
    parameter int IDX_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             done_i,
    input  logic             stream_start_i,
    input  logic             out_ready_i,
    input  logic [1:0]       k_i,
    input  logic [1:0]       m_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic             capture_o,
    output logic             full_o,
    output logic             overrun_o,
    output state_e           state_o
);
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic             overrun_q, overrun_d;
    logic             row_end, col_end, hs;

    assign row_end     = 32'(row_q) == 32'(k_i);
    assign col_end     = 32'(col_q) == 32'(m_i);
    assign out_valid_o = (state_q == ST_STREAM);
    assign out_last_o  = out_valid_o && row_end && col_end;
    assign hs          = out_valid_o && out_ready_i;
    // A done pulse during STREAM is not a capture; it only raises overrun.
    assign capture_o   = done_i && !clear_i && (state_q != ST_STREAM);
    assign full_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign state_o     = state_e'(state_q);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        if (clear_i) begin
            state_d   = ST_IDLE;
            row_d     = '0;
            col_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (done_i) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!done_i && stream_start_i) begin
                        state_d = ST_STREAM;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                ST_STREAM: begin
                    if (done_i) overrun_d = 1'b1;
                    if (hs) begin
                        if (row_end && col_end) begin
                            state_d = ST_HOLD;
                            row_d   = '0;
                            col_d   = '0;
                        end else if (col_end) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/result_matrix_reader.sv
// Captures result matrix C from the systolic array and returns it via a 1-cycle
// random-access read port and a row-major drain stream. Optional: RESULT_ACCUM_EN.
module result_matrix_reader
    import matmul_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int BUS_WIDTH  = BUS_WIDTH_DEF,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 done_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] res_i,
    input  logic [1:0]                           k_i,
    input  logic [1:0]                           m_i,
    input  logic                                 clear_i,
`ifdef RESULT_ACCUM_EN
    input  logic                                 accum_i,
`endif
    output logic                                 full_o,
    output logic                                 overrun_o,
    result_matrix_reader_if.slave                bus
);
    logic [BUS_WIDTH-1:0] mat [MAX_DIM][MAX_DIM];
    logic [IDX_W-1:0]     row, col;
    logic                 capture, accum, rd_hit;
    logic                 rd_valid_q;
    logic [BUS_WIDTH-1:0] rd_data_q;
    state_e               ctrl_state;

    rm_stream_ctrl #(.IDX_W(IDX_W)) u_ctrl (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .done_i         (done_i),
        .stream_start_i (bus.stream_start),
        .out_ready_i    (bus.out_ready),
        .k_i            (k_i),
        .m_i            (m_i),
        .row_o          (row),
        .col_o          (col),
        .out_valid_o    (bus.out_valid),
        .out_last_o     (bus.out_last),
        .capture_o      (capture),
        .full_o         (full_o),
        .overrun_o      (overrun_o),
        .state_o        (ctrl_state)
    );

    // Captures only happen from IDLE or HOLD, and IDLE always overwrites.
`ifdef RESULT_ACCUM_EN
    assign accum = accum_i && (ctrl_state == HOLD);
`else
    assign accum = 1'b0;
`endif

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            logic [BUS_WIDTH-1:0] elem_q, elem_d, res_e;
            logic                 in_range;

            assign res_e    = res_i[elem_off(r, c, MAX_DIM, BUS_WIDTH) +: BUS_WIDTH];
            assign in_range = (32'(r) <= 32'(k_i)) && (32'(c) <= 32'(m_i));
            assign mat[r][c] = elem_q;

            always_comb begin
                elem_d = elem_q;
                if (clear_i) begin
                    elem_d = '0;
                end else if (capture) begin
                    elem_d = in_range ? (res_e + (accum ? elem_q : '0)) : '0;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) elem_q <= '0;
                else         elem_q <= elem_d;
            end
        end
    end

    assign bus.out_data = bus.out_valid ? mat[row][col] : '0;

    assign rd_hit = (ctrl_state != IDLE) &&
                    (32'(bus.rd_row) <= 32'(k_i)) &&
                    (32'(bus.rd_col) <= 32'(m_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_hit ? mat[bus.rd_row][bus.rd_col] : '0;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_result_matrix_reader.sv
// Bench for result_matrix_reader: directed scenarios plus random traffic, all
// checked against a matrix/queue reference model.
module tb_result_matrix_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        done_i, clear_i;
    logic [63:0] res_i;
    logic [1:0]  k_i, m_i;
    logic        full_o, overrun_o;
`ifdef RESULT_ACCUM_EN
    logic        accum_i;
`endif

    result_matrix_reader_if #(.BUS_WIDTH(16), .IDX_W(1)) bus ();

    result_matrix_reader #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .done_i    (done_i),
        .res_i     (res_i),
        .k_i       (k_i),
        .m_i       (m_i),
        .clear_i   (clear_i),
`ifdef RESULT_ACCUM_EN
        .accum_i   (accum_i),
`endif
        .full_o    (full_o),
        .overrun_o (overrun_o),
        .bus       (bus)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: matrix contents, mode, and the scoreboard of pending stream elements
    logic [15:0] m_mat [2][2];
    int          m_state;   // 0 empty, 1 holding, 2 draining
    bit          m_ovr, m_rdv;
    logic [15:0] m_rdd;
    logic [15:0] exp_q [$];

    task automatic model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) m_mat[r][c] = 16'h0;
        m_state = 0;
        m_ovr   = 1'b0;
        m_rdv   = 1'b0;
        m_rdd   = 16'h0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [15:0] old [2][2];
        logic [15:0] e;
        int          st;
        bit          hs, acc;
        old = m_mat;
        st  = m_state;
        hs  = (st == 2) && bus.out_ready;
`ifdef RESULT_ACCUM_EN
        acc = accum_i && (st == 1);
`else
        acc = 1'b0;
`endif
        m_rdv = bus.rd_en;
        if (bus.rd_en)
            m_rdd = (st == 0 || bus.rd_row > k_i || bus.rd_col > m_i) ? 16'h0 : old[bus.rd_row][bus.rd_col];
        if (clear_i) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) m_mat[r][c] = 16'h0;
            m_state = 0;
            m_ovr   = 1'b0;
            exp_q.delete();
        end else begin
            if (done_i && st != 2) begin
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++) begin
                        e = res_i[(r*2+c)*16 +: 16];
                        m_mat[r][c] = (r <= k_i && c <= m_i) ? (acc ? old[r][c] + e : e) : 16'h0;
                    end
                m_state = 1;
            end else if (done_i) begin
                m_ovr = 1'b1;
            end
            if (st == 2 && hs) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_state = 1;
            end
            if (st == 1 && bus.stream_start && !done_i) begin
                for (int r = 0; r <= int'(k_i); r++)
                    for (int c = 0; c <= int'(m_i); c++) exp_q.push_back(m_mat[r][c]);
                m_state = 2;
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid", bus.out_valid, m_state == 2);
        if (m_state == 2 && exp_q.size() > 0) begin
            check("out_data", bus.out_data, exp_q[0]);
            check("out_last", bus.out_last, exp_q.size() == 1);
        end
        check("full", full_o, m_state != 0);
        check("overrun", overrun_o, m_ovr);
        check("rd_valid", bus.rd_valid, m_rdv);
        check("rd_data", bus.rd_data, m_rdd);
    endtask

    // driver tasks
    task automatic idle_in();
        done_i           = 1'b0;
        clear_i          = 1'b0;
        bus.rd_en        = 1'b0;
        bus.stream_start = 1'b0;
        bus.out_ready    = 1'b0;
`ifdef RESULT_ACCUM_EN
        accum_i          = 1'b0;
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic set_res(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
        res_i = {d, c, b, a};
    endtask

    task automatic capture(logic [1:0] k, logic [1:0] m);
        k_i = k; m_i = m; done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic read(logic r, logic c);
        bus.rd_en = 1'b1; bus.rd_row = r; bus.rd_col = c;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got_q [$];
        int          pat [7];
        idle_in();
        k_i = 2'd0; m_i = 2'd0; res_i = '0;
        bus.rd_row = 1'b0; bus.rd_col = 1'b0;
        model_reset();
        #3;
        compare_all();
        check("rst_out_data", bus.out_data, 16'h0);
        #9 rst_ni = 1'b1;

        // capture and read
        set_res(16'h1, 16'h2, 16'h3, 16'h4);
        capture(2'd1, 2'd1);
        read(1'b1, 1'b0);
        check("t1_rd_data", bus.rd_data, 16'h3);
        check("t1_rd_valid", bus.rd_valid, 1'b1);
        check("t1_full", full_o, 1'b1);
        tick();
        check("t1_rd_valid_low", bus.rd_valid, 1'b0);

        // dimension masking
        set_res(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        capture(2'd0, 2'd1);
        read(1'b1, 1'b1);
        check("t2_rd_masked", bus.rd_data, 16'h0);
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        check("t2_first", bus.out_data, 16'h1111);
        check("t2_first_last", bus.out_last, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("t2_second", bus.out_data, 16'h2222);
        check("t2_second_last", bus.out_last, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        check("t2_done_valid", bus.out_valid, 1'b0);

        // backpressure
        set_res(16'h1, 16'h2, 16'h3, 16'h4);
        capture(2'd1, 2'd1);
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i][0];
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            tick();
        end
        bus.out_ready = 1'b0;
        check("t3_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++) check("t3_seq", got_q[i], i + 1);
        check("t3_hold_valid", bus.out_valid, 1'b0);
        check("t3_hold_full", full_o, 1'b1);
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        check("t3_restart", bus.out_data, 16'h1);

        // overrun and clear
        set_res(16'h9, 16'h9, 16'h9, 16'h9);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("t4_overrun", overrun_o, 1'b1);
        check("t4_data_kept", bus.out_data, 16'h1);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        read(1'b1, 1'b1);
        check("t4_mat_kept", bus.rd_data, 16'h4);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("t4_clr_full", full_o, 1'b0);
        check("t4_clr_overrun", overrun_o, 1'b0);
        read(1'b0, 1'b0);
        check("t4_clr_rd", bus.rd_data, 16'h0);

        // async reset mid-stream
        set_res(16'h5, 16'h6, 16'h7, 16'h8);
        capture(2'd1, 2'd1);
        bus.stream_start = 1'b1;
        bus.rd_en = 1'b1; bus.rd_row = 1'b1; bus.rd_col = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        bus.rd_en = 1'b0;
        check("t5_pre_rd", bus.rd_data, 16'h8);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        model_reset();
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_data", bus.out_data, 16'h0);
        check("t5_rst_last", bus.out_last, 1'b0);
        check("t5_rst_full", full_o, 1'b0);
        check("t5_rst_rd_data", bus.rd_data, 16'h0);
        check("t5_rst_rd_valid", bus.rd_valid, 1'b0);
        #3 rst_ni = 1'b1;
        bus.stream_start = 1'b1;
        tick();
        bus.stream_start = 1'b0;
        check("t5_idle_start", bus.out_valid, 1'b0);

`ifdef RESULT_ACCUM_EN
        set_res(16'h1, 16'h2, 16'h3, 16'h4);
        capture(2'd1, 2'd1);
        set_res(16'hFFFF, 16'h1, 16'h1, 16'h1);
        accum_i = 1'b1;
        capture(2'd1, 2'd1);
        accum_i = 1'b0;
        read(1'b0, 1'b0); check("t6_acc00", bus.rd_data, 16'h0);
        read(1'b0, 1'b1); check("t6_acc01", bus.rd_data, 16'h3);
        read(1'b1, 1'b0); check("t6_acc10", bus.rd_data, 16'h4);
        read(1'b1, 1'b1); check("t6_acc11", bus.rd_data, 16'h5);
`endif

        // random traffic
        repeat (600) begin
            idle_in();
            done_i = ($urandom_range(0, 7) == 0);
            res_i  = {$urandom, $urandom};
            if (done_i && m_state != 2) begin
                k_i = 2'($urandom_range(0, 1));
                m_i = 2'($urandom_range(0, 1));
            end
            bus.stream_start = ($urandom_range(0, 3) == 0);
            bus.out_ready    = 1'($urandom_range(0, 1));
            bus.rd_en        = 1'($urandom_range(0, 1));
            bus.rd_row       = 1'($urandom_range(0, 1));
            bus.rd_col       = 1'($urandom_range(0, 1));
            clear_i          = ($urandom_range(0, 39) == 0);
`ifdef RESULT_ACCUM_EN
            accum_i          = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
